// File: rtl/frame_writer.sv
// Raster-order framebuffer writer: packs the shaded RGB888 stream to RGB444, writes it
// at a running address, tracks the next (x,y) pixel and pulses frame_done once per frame.
module frame_writer #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 15,
    parameter int X_W    = 8,
    parameter int Y_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [23:0]       color,
    input  logic              color_valid,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_wdata,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_cnt;

    // NOTE: every register here is assigned with <= so all updates see pre-edge values;
    // a blocking assignment would let later statements observe the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_cnt   <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        addr_cnt <= '0;
                        pix_x    <= '0;
                        pix_y    <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (color_valid) begin
                        fb_we    <= 1'b1;
                        fb_addr  <= addr_cnt;
                        fb_wdata <= {color[23:20], color[15:12], color[7:4]};
                        addr_cnt <= addr_cnt + 1'b1;
                        if (pix_x == X_LAST) begin
                            pix_x <= '0;
                            if (pix_y == Y_LAST) begin
                                pix_y <= '0;
                                state <= S_DONE;
                            end else begin
                                pix_y <= pix_y + 1'b1;
                            end
                        end else begin
                            pix_x <= pix_x + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: directed scenarios with literal expectations, then random
// traffic checked every cycle against a pixel-count model of the frame.
module tb_frame_writer;
    localparam int H = 4;
    localparam int V = 3;
    localparam int AW = 4;
    localparam int XW = 2;
    localparam int YW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [23:0]   color = '0;
    logic          color_valid = 1'b0;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [11:0]   fb_wdata;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_fail = 0;

    frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .X_W(XW), .Y_W(YW)) dut (
        .clk(clk), .rst(rst), .start(start), .color(color), .color_valid(color_valid),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .pix_x(pix_x),
        .pix_y(pix_y), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pack(input logic [23:0] c);
        return {c[23:20], c[15:12], c[7:4]};
    endfunction

    // Model: a frame is a count of accepted pixels; position and address derive from it.
    int   m_n = 0;
    bit   m_active = 0;
    bit   m_done_pend = 0;
    bit   m_rst = 1;
    logic        e_we = 0, e_fd = 0, e_busy = 0;
    logic [31:0] e_addr = 0, e_wdata = 0;

    always @(posedge clk) begin
        e_we = 0;
        e_fd = 0;
        m_rst = rst;
        if (rst) begin
            m_n = 0; m_active = 0; m_done_pend = 0;
            e_busy = 0; e_addr = 0; e_wdata = 0;
        end else if (m_done_pend) begin
            m_done_pend = 0;
            e_fd = 1;
            e_busy = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_n = 0; e_busy = 1;
            end
        end else if (color_valid) begin
            e_we = 1;
            e_addr = m_n;
            e_wdata = 32'(pack(color));
            m_n++;
            if (m_n == H * V) begin
                m_n = 0; m_active = 0; m_done_pend = 1;
            end
        end
        #1;
        check("fb_we", 32'(fb_we), 32'(e_we));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("busy", 32'(busy), 32'(e_busy));
        check("pix_x", 32'(pix_x), m_n % H);
        check("pix_y", 32'(pix_y), m_n / H);
        if (e_we || m_rst) begin
            check("fb_addr", 32'(fb_addr), e_addr);
            check("fb_wdata", 32'(fb_wdata), e_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (frame_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_timeout: got none expected pulse within %0d cycles", budget);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(); step();
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_wdata", 32'(fb_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        rst = 1'b0;

        // Valids in IDLE are ignored
        color = 24'hFFFFFF; color_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_we", 32'(fb_we), 0);
            check("idle_x", 32'(pix_x), 0);
        end
        color_valid = 1'b0;

        // Back-to-back frame
        start = 1'b1; step(); start = 1'b0;
        check("s3_busy", 32'(busy), 1);
        color = 24'hABCDEF; color_valid = 1'b1;
        for (int i = 0; i < H * V; i++) begin
            step();
            check("s3_we", 32'(fb_we), 1);
            check("s3_addr", 32'(fb_addr), i);
            check("s3_wdata", 32'(fb_wdata), 32'h0ACE);
        end
        color_valid = 1'b0;
        step();
        check("s3_done", 32'(frame_done), 1);
        check("s3_busy_end", 32'(busy), 0);
        check("s3_we_end", 32'(fb_we), 0);
        step();
        check("s3_done_pulse", 32'(frame_done), 0);

        // Valids every other cycle
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < H * V; i++) begin
            color = 24'($urandom); color_valid = 1'b1;
            step();
            check("s4_we", 32'(fb_we), 1);
            check("s4_addr", 32'(fb_addr), i);
            color_valid = 1'b0;
            step();
            check("s4_gap_we", 32'(fb_we), 0);
            if (i == 3) begin
                check("s4_x", 32'(pix_x), 0);
                check("s4_y", 32'(pix_y), 1);
            end
            if (i == H * V - 1) check("s4_done", 32'(frame_done), 1);
        end

        // start during RUN is ignored
        start = 1'b1; step(); start = 1'b0;
        color_valid = 1'b1; step(); step();
        color_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
        check("s5_x", 32'(pix_x), 2);
        check("s5_busy", 32'(busy), 1);
        color_valid = 1'b1; step();
        check("s5_addr", 32'(fb_addr), 2);
        wait_done(40);
        color_valid = 1'b0;
        step();

        // Reset mid-frame
        start = 1'b1; step(); start = 1'b0;
        color_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1; color_valid = 1'b0; step(); rst = 1'b0;
        check("s6_we", 32'(fb_we), 0);
        check("s6_addr", 32'(fb_addr), 0);
        check("s6_x", 32'(pix_x), 0);
        check("s6_y", 32'(pix_y), 0);
        check("s6_busy", 32'(busy), 0);
        step();
        check("s6_no_done", 32'(frame_done), 0);
        start = 1'b1; step(); start = 1'b0;
        color_valid = 1'b1; step();
        check("s6_first_addr", 32'(fb_addr), 0);
        wait_done(40);
        color_valid = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 300) == 0;
            start = ($urandom % 12) == 0;
            color_valid = ($urandom % 3) != 0;
            color = 24'($urandom);
            step();
        end
        rst = 1'b0; start = 1'b0; color_valid = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
